// File: rtl/csel_pkg.sv
// Shared helpers for the pipelined carry-select adder: segment/stage counting,
// segment bit boundaries and the per-stage control register layout.
package csel_pkg;

  // Per-stage handshake/carry state; the data fields are sized by the top.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  // Number of SEG_W-bit segments needed to cover WIDTH bits.
  function automatic int unsigned nseg(int unsigned width, int unsigned seg_w);
    return (width + seg_w - 1) / seg_w;
  endfunction

  // Number of pipeline stages needed for nseg_n segments.
  function automatic int unsigned nstg(int unsigned nseg_n, int unsigned segs_per_stg);
    return (nseg_n + segs_per_stg - 1) / segs_per_stg;
  endfunction

  // Lowest bit of segment 'seg', clamped to width so the last segment may be narrower.
  function automatic int unsigned seg_bit(int unsigned seg, int unsigned width,
                                          int unsigned seg_w);
    return (seg * seg_w < width) ? seg * seg_w : width;
  endfunction

endpackage

// File: rtl/csel_segment.sv
// Combinational carry-select segment.
// Ports: a, b (W bits) and cin in; sum (W bits) and cout out.
// Two ripple chains precompute the result for carry-in 0 and 1; cin picks one.
module csel_segment #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] sum0;
  logic [W-1:0] sum1;
  logic         cout0;
  logic         cout1;

  // Dual ripple chains, one per assumed carry-in.
  always_comb begin
    logic k0;
    logic k1;
    sum0  = '0;
    sum1  = '0;
    k0    = 1'b0;
    k1    = 1'b1;
    for (int i = 0; i < int'(W); i++) begin
      sum0[i] = a[i] ^ b[i] ^ k0;
      sum1[i] = a[i] ^ b[i] ^ k1;
      k0      = (a[i] & b[i]) | (k0 & (a[i] ^ b[i]));
      k1      = (a[i] & b[i]) | (k1 & (a[i] ^ b[i]));
    end
    cout0 = k0;
    cout1 = k1;
  end

  assign sum  = cin ? sum1 : sum0;
  assign cout = cin ? cout1 : cout0;

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control.
// Ports: clk, rst_n (async, active low); in_valid/in_ready with in_a, in_b,
// in_cin, in_sub; out_valid/out_ready with out_sum, out_cout, out_ovf.
// Each stage resolves SEGS_PER_STG segments and registers the resolved sum
// bits, the running carry and the operand bits still to be added.
module pipelined_csel_adder
  import csel_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned SEG_W        = 4,
  parameter int unsigned SEGS_PER_STG = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned NSEG = nseg(WIDTH, SEG_W);
  localparam int unsigned NSTG = nstg(NSEG, SEGS_PER_STG);

  logic [NSTG-1:0]  stg_valid;
  logic [NSTG-1:0]  stg_load;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Subtraction becomes A + ~B + 1 at acceptance; in_cin is ignored then.
  assign b_eff   = in_sub ? ~in_b : in_b;
  assign cin_eff = in_sub | in_cin;

  // Stage k may load when empty or when its contents move on this edge.
  always_comb begin
    logic rdy;
    rdy      = out_ready;
    stg_load = '0;
    for (int k = int'(NSTG) - 1; k >= 0; k--) begin
      rdy         = !stg_valid[k] || rdy;
      stg_load[k] = rdy;
    end
  end

  assign in_ready  = stg_load[0];
  assign out_valid = stg_valid[NSTG-1];

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int unsigned S0 = k * SEGS_PER_STG;
    localparam int unsigned S1 = (S0 + SEGS_PER_STG < NSEG) ? S0 + SEGS_PER_STG : NSEG;
    localparam int unsigned NS = S1 - S0;
    localparam int unsigned LO = seg_bit(S0, WIDTH, SEG_W);
    localparam int unsigned HI = seg_bit(S1, WIDTH, SEG_W);

    logic [WIDTH-LO-1:0] a_in;
    logic [WIDTH-LO-1:0] b_in;
    logic [HI-LO-1:0]    seg_sum;
    logic [HI-1:0]       sum_d;
    logic [HI-1:0]       sum_q;
    logic                cin_stg;
    logic                cout_stg;
    logic                up_valid;
    stage_ctl_t          ctl_q;

    // Stage inputs: the accepted beat, or the previous stage's registers.
    if (k == 0) begin : g_src
      assign a_in     = in_a;
      assign b_in     = b_eff;
      assign cin_stg  = cin_eff;
      assign up_valid = in_valid;
      assign sum_d    = seg_sum;
    end else begin : g_src
      assign a_in     = g_stg[k-1].g_rem.a_q;
      assign b_in     = g_stg[k-1].g_rem.b_q;
      assign cin_stg  = g_stg[k-1].g_rem.carry_o;
      assign up_valid = stg_valid[k-1];
      assign sum_d    = {seg_sum, g_stg[k-1].sum_q};
    end

    // Segment chain; each segment's carry selects the next one's precomputed pair.
    for (genvar j = 0; j < NS; j++) begin : g_seg
      localparam int unsigned SL = seg_bit(S0 + j, WIDTH, SEG_W);
      localparam int unsigned SH = seg_bit(S0 + j + 1, WIDTH, SEG_W);

      logic ci;
      logic co;

      if (j == 0) begin : g_ci
        assign ci = cin_stg;
      end else begin : g_ci
        assign ci = g_seg[j-1].co;
      end

      csel_segment #(.W(SH - SL)) u_seg (
        .a    (a_in[SL-LO +: SH-SL]),
        .b    (b_in[SL-LO +: SH-SL]),
        .cin  (ci),
        .sum  (seg_sum[SL-LO +: SH-SL]),
        .cout (co)
      );
    end

    assign cout_stg     = g_seg[NS-1].co;
    assign stg_valid[k] = ctl_q.valid;

    // Control and resolved-sum register; data holds when no beat arrives.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctl_q <= '0;
        sum_q <= '0;
      end else if (stg_load[k]) begin
        ctl_q.valid <= up_valid;
        if (up_valid) begin
          ctl_q.carry <= cout_stg;
          sum_q       <= sum_d;
        end
      end
    end

    if (k + 1 < NSTG) begin : g_rem
      logic [WIDTH-HI-1:0] a_q;
      logic [WIDTH-HI-1:0] b_q;
      logic                carry_o;

      assign carry_o = ctl_q.carry;

      // Operand bits above this stage, carried forward for later stages.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (stg_load[k] && up_valid) begin
          a_q <= a_in[WIDTH-LO-1:HI-LO];
          b_q <= b_in[WIDTH-LO-1:HI-LO];
        end
      end
    end else begin : g_out
      logic ovf_q;

      // The last stage still sees both operand MSBs, so overflow is formed here.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (stg_load[k] && up_valid) begin
          ovf_q <= (a_in[WIDTH-LO-1] == b_in[WIDTH-LO-1]) &&
                   (seg_sum[HI-LO-1] != a_in[WIDTH-LO-1]);
        end
      end

      assign out_sum  = sum_q;
      assign out_cout = ctl_q.carry;
      assign out_ovf  = ovf_q;
    end
  end

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Self-checking bench for pipelined_csel_adder: directed arithmetic cases,
// streaming, back-pressure, mid-flight reset and randomized traffic on two
// configurations (16/4/2 and 13/4/1) against an integer-arithmetic model.
module tb_pipelined_csel_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic        v1, r1, c1i, s1i, ov1, or1, co1, of1;
  logic [15:0] a1, b1, sum1;

  logic        v2, r2, c2i, s2i, ov2, or2, co2, of2;
  logic [12:0] a2, b2, sum2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipelined_csel_adder #(.WIDTH(16), .SEG_W(4), .SEGS_PER_STG(2)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v1), .in_ready(r1), .in_a(a1), .in_b(b1), .in_cin(c1i), .in_sub(s1i),
    .out_valid(ov1), .out_ready(or1), .out_sum(sum1), .out_cout(co1), .out_ovf(of1)
  );

  pipelined_csel_adder #(.WIDTH(13), .SEG_W(4), .SEGS_PER_STG(1)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v2), .in_ready(r2), .in_a(a2), .in_b(b2), .in_cin(c2i), .in_sub(s2i),
    .out_valid(ov2), .out_ready(or2), .out_sum(sum2), .out_cout(co2), .out_ovf(of2)
  );

  // Reference: integer arithmetic. Returns {ovf, cout, sum[31:0]}.
  function automatic logic [33:0] golden(input int w, input logic [31:0] a,
                                         input logic [31:0] b, input logic cin,
                                         input logic sub);
    longint unsigned mask, ua, ub, tot;
    longint          half, sa, sb, st;
    logic [31:0]     sum;
    logic            cout, ovf;
    mask = (64'd1 << w) - 64'd1;
    ua   = 64'(a) & mask;
    ub   = 64'(b) & mask;
    if (sub) tot = ua + ((~ub) & mask) + 64'd1;
    else     tot = ua + ub + 64'(cin);
    sum  = 32'(tot & mask);
    cout = tot[w];
    half = longint'(1) << (w - 1);
    sa   = longint'(ua);
    sb   = longint'(ub);
    if (sa >= half) sa = sa - 2 * half;
    if (sb >= half) sb = sb - 2 * half;
    st   = sub ? (sa - sb) : (sa + sb + longint'(cin));
    ovf  = (st >= half) || (st < -half);
    return {ovf, cout, sum};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (ov1 !== 1'b0)     begin bad++; $display("FAIL reset_out_valid got=%b want=0", ov1); end
    total++; if (sum1 !== 16'h0)   begin bad++; $display("FAIL reset_out_sum got=%h want=0000", sum1); end
    total++; if (co1 !== 1'b0)     begin bad++; $display("FAIL reset_out_cout got=%b want=0", co1); end
    total++; if (of1 !== 1'b0)     begin bad++; $display("FAIL reset_out_ovf got=%b want=0", of1); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (r1 !== 1'b1)      begin bad++; $display("FAIL reset_in_ready got=%b want=1", r1); end
    total++; if (ov2 !== 1'b0)     begin bad++; $display("FAIL reset_out_valid2 got=%b want=0", ov2); end
    total++; if (r2 !== 1'b1)      begin bad++; $display("FAIL reset_in_ready2 got=%b want=1", r2); end
  endtask

  task automatic test_arith();
    logic [15:0] ta [6];
    logic [15:0] tb [6];
    logic        tc [6];
    logic        ts [6];
    logic [15:0] es [6];
    logic        ec [6];
    logic        eo [6];
    ta = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234, 16'h00FF};
    tb = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h1234, 16'h0000};
    tc = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b1};
    ts = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b1,     1'b0};
    es = '{16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h0000, 16'h0100};
    ec = '{1'b1,     1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
    eo = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a1 = ta[i]; b1 = tb[i]; c1i = tc[i]; s1i = ts[i]; v1 = 1'b1; or1 = 1'b1;
      #1;
      total++; if (r1 !== 1'b1) begin bad++; $display("FAIL arith_in_ready[%0d] got=%b want=1", i, r1); end
      @(negedge clk);
      v1 = 1'b0;
      #1;
      total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL arith_latency[%0d] out_valid after 1 cycle got=%b want=0", i, ov1); end
      @(negedge clk);
      #1;
      total++; if (ov1 !== 1'b1) begin bad++; $display("FAIL arith_valid[%0d] got=%b want=1", i, ov1); end
      total++; if (sum1 !== es[i]) begin bad++; $display("FAIL arith_sum[%0d] got=%h want=%h", i, sum1, es[i]); end
      total++; if (co1 !== ec[i]) begin bad++; $display("FAIL arith_cout[%0d] got=%b want=%b", i, co1, ec[i]); end
      total++; if (of1 !== eo[i]) begin bad++; $display("FAIL arith_ovf[%0d] got=%b want=%b", i, of1, eo[i]); end
    end
  endtask

  task automatic test_stream();
    logic [33:0] exp_q[$];
    logic [33:0] e;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      or1 = 1'b1;
      if (cyc < 8) begin
        a1 = 16'($urandom); b1 = 16'($urandom);
        c1i = 1'($urandom); s1i = 1'($urandom); v1 = 1'b1;
        exp_q.push_back(golden(16, 32'(a1), 32'(b1), c1i, s1i));
      end else begin
        v1 = 1'b0;
      end
      #1;
      total++;
      if (ov1 !== 1'((cyc >= 2) && (cyc < 10))) begin
        bad++; $display("FAIL stream_valid cyc=%0d got=%b want=%b", cyc, ov1, (cyc >= 2) && (cyc < 10));
      end
      if (ov1 === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({of1, co1, sum1} !== {e[33], e[32], e[15:0]}) begin
          bad++; $display("FAIL stream_data cyc=%0d got=%b/%b/%h want=%b/%b/%h",
                          cyc, of1, co1, sum1, e[33], e[32], e[15:0]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] exp_q[$];
    logic [33:0] e;
    logic [33:0] first;
    int          got = 0;
    bit          acc = 1'b0;
    or1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a1 = 16'($urandom); b1 = 16'($urandom);
      c1i = 1'($urandom); s1i = 1'($urandom); v1 = 1'b1;
      #1;
      total++;
      if (r1 !== 1'(i < 2)) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b want=%b", i, r1, i < 2); end
      if (r1 === 1'b1) exp_q.push_back(golden(16, 32'(a1), 32'(b1), c1i, s1i));
    end
    first = golden(16, 32'(exp_q.size() > 0 ? 32'(0) : 32'(0)), 32'(0), 1'b0, 1'b0);
    first = (exp_q.size() > 0) ? exp_q[0] : first;
    for (int h = 0; h < 3; h++) begin
      if (h > 0) @(negedge clk);
      #1;
      total++; if (r1 !== 1'b0) begin bad++; $display("FAIL bp_hold_ready[%0d] got=%b want=0", h, r1); end
      total++;
      if ({ov1, of1, co1, sum1} !== {1'b1, first[33], first[32], first[15:0]}) begin
        bad++; $display("FAIL bp_hold_out[%0d] got=%b/%b/%b/%h want=1/%b/%b/%h",
                        h, ov1, of1, co1, sum1, first[33], first[32], first[15:0]);
      end
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (acc) v1 = 1'b0;
      or1 = 1'b1;
      #1;
      acc = v1 && r1;
      if (acc) exp_q.push_back(golden(16, 32'(a1), 32'(b1), c1i, s1i));
      if (ov1 === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL bp_extra got=%h want=none", sum1);
        end else begin
          e = exp_q.pop_front();
          if ({of1, co1, sum1} !== {e[33], e[32], e[15:0]}) begin
            bad++; $display("FAIL bp_data[%0d] got=%b/%b/%h want=%b/%b/%h",
                            got, of1, co1, sum1, e[33], e[32], e[15:0]);
          end
        end
        got++;
      end
    end
    v1 = 1'b0;
    total++; if (got != 3) begin bad++; $display("FAIL bp_count got=%0d want=3", got); end
  endtask

  task automatic test_reset_midflight();
    or1 = 1'b0;
    @(negedge clk);
    a1 = 16'h1111; b1 = 16'h2222; c1i = 1'b0; s1i = 1'b0; v1 = 1'b1;
    @(negedge clk);
    a1 = 16'h0F0F; b1 = 16'h0101; c1i = 1'b1; s1i = 1'b0; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    #1;
    total++; if (ov1 !== 1'b1) begin bad++; $display("FAIL rst_mid_queued got=%b want=1", ov1); end
    rst_n = 1'b0;
    #1;
    total++; if (ov1 !== 1'b0)   begin bad++; $display("FAIL rst_mid_valid got=%b want=0", ov1); end
    total++; if (sum1 !== 16'h0) begin bad++; $display("FAIL rst_mid_sum got=%h want=0000", sum1); end
    total++; if (r1 !== 1'b1)    begin bad++; $display("FAIL rst_mid_ready got=%b want=1", r1); end
    @(negedge clk);
    rst_n = 1'b1;
    or1   = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      #1;
      total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL rst_mid_stale cyc=%0d got=%b want=0", cyc, ov1); end
    end
  endtask

  task automatic test_random_cfg1(input int n);
    logic [33:0] exp_q[$];
    logic [33:0] e;
    logic [17:0] held;
    int          sent = 0, got = 0, cyc = 0;
    bit          acc = 1'b0, stalled = 1'b0;
    v1 = 1'b0;
    while (got < n && cyc < n * 10) begin
      @(negedge clk);
      cyc++;
      if (acc) v1 = 1'b0;
      if (!v1 && sent < n && $urandom_range(0, 3) != 0) begin
        a1  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        b1  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        c1i = 1'($urandom); s1i = 1'($urandom); v1 = 1'b1;
      end
      or1 = ($urandom_range(0, 3) != 0);
      #1;
      if (stalled) begin
        total++;
        if ({ov1, of1, co1, sum1} !== {1'b1, held}) begin
          bad++; $display("FAIL rand16_stall_hold got=%b/%b/%b/%h want=1/%b/%b/%h",
                          ov1, of1, co1, sum1, held[17], held[16], held[15:0]);
        end
      end
      stalled = (ov1 === 1'b1) && !or1;
      held    = {of1, co1, sum1};
      acc = v1 && (r1 === 1'b1);
      if (acc) begin
        exp_q.push_back(golden(16, 32'(a1), 32'(b1), c1i, s1i));
        sent++;
      end
      if (ov1 === 1'b1 && or1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand16_extra got=%h want=none", sum1);
        end else begin
          e = exp_q.pop_front();
          if ({of1, co1, sum1} !== {e[33], e[32], e[15:0]}) begin
            bad++; $display("FAIL rand16_data[%0d] got=%b/%b/%h want=%b/%b/%h",
                            got, of1, co1, sum1, e[33], e[32], e[15:0]);
          end
        end
        got++;
      end
    end
    v1 = 1'b0; or1 = 1'b1;
    total++; if (got != n) begin bad++; $display("FAIL rand16_count got=%0d want=%0d", got, n); end
  endtask

  task automatic test_random_cfg2(input int n);
    logic [33:0] exp_q[$];
    logic [33:0] e;
    int          sent = 0, got = 0, cyc = 0;
    bit          acc = 1'b0;
    v2 = 1'b0;
    while (got < n && cyc < n * 10) begin
      @(negedge clk);
      cyc++;
      if (acc) v2 = 1'b0;
      if (!v2 && sent < n && $urandom_range(0, 3) != 0) begin
        a2  = ($urandom_range(0, 7) == 0) ? 13'h1FFF : 13'($urandom);
        b2  = ($urandom_range(0, 7) == 0) ? 13'h1FFF : 13'($urandom);
        c2i = 1'($urandom); s2i = 1'($urandom); v2 = 1'b1;
      end
      or2 = ($urandom_range(0, 3) != 0);
      #1;
      acc = v2 && (r2 === 1'b1);
      if (acc) begin
        exp_q.push_back(golden(13, 32'(a2), 32'(b2), c2i, s2i));
        sent++;
      end
      if (ov2 === 1'b1 && or2) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand13_extra got=%h want=none", sum2);
        end else begin
          e = exp_q.pop_front();
          if ({of2, co2, sum2} !== {e[33], e[32], e[12:0]}) begin
            bad++; $display("FAIL rand13_data[%0d] got=%b/%b/%h want=%b/%b/%h",
                            got, of2, co2, sum2, e[33], e[32], e[12:0]);
          end
        end
        got++;
      end
    end
    v2 = 1'b0; or2 = 1'b1;
    total++; if (got != n) begin bad++; $display("FAIL rand13_count got=%0d want=%0d", got, n); end
  endtask

  initial begin
    v1 = 1'b0; a1 = '0; b1 = '0; c1i = 1'b0; s1i = 1'b0; or1 = 1'b1;
    v2 = 1'b0; a2 = '0; b2 = '0; c2i = 1'b0; s2i = 1'b0; or2 = 1'b1;
    test_reset();
    test_arith();
    test_stream();
    test_backpressure();
    test_reset_midflight();
    test_random_cfg1(10000);
    test_random_cfg2(10000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
